apb3_cmd_requester: RTL and testbench

Synthesizable APB3 requester driven by a command queue. Sits between an upstream command source (pattern generator, CPU-side bridge, or bench sequencer) and the APB3 bus served by the Renode APB3 completer. Accepts write/read commands over a valid/ready channel and buffers them in a FIFO. Executes each command as an APB3 SETUP/ACCESS transfer with wait-state support and a timeout, then returns read data and status over a valid/ready response channel.

---
 rtl/apb3_cmd_requester.sv | 207 ++++++++++++++++++++
 tb/tb_apb3_cmd_requester.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_cmd_requester.sv
`default_nettype none
// ============================================================================
// Module      : apb3_cmd_requester
// Description : Command-FIFO-fed APB3 requester with wait states, ACCESS
//               timeout and a single-entry response slot with stall buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module apb3_cmd_requester #(
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32,
  parameter int FifoDepth     = 4,
  parameter int TimeoutCycles = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [AddressWidth-1:0] cmd_addr,
  input  logic [DataWidth-1:0]    cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataWidth-1:0]    rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [AddressWidth-1:0] paddr,
  output logic                    pwrite,
  output logic [DataWidth-1:0]    pwdata,
  output logic                    psel,
  output logic                    penable,
  input  logic [DataWidth-1:0]    prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_STALL  = 2'd3;

  localparam logic [PW:0]   C_PTR_ONE  = (PW+1)'(1);
  localparam logic [TW-1:0] C_TCNT_ONE = TW'(1);
  localparam logic [TW-1:0] C_TLAST    = TW'(TimeoutCycles - 1);

  logic [1:0]              r_state;
  logic [PW:0]             r_wr_ptr;
  logic [PW:0]             r_rd_ptr;
  logic                    r_fifo_write [FifoDepth];
  logic [AddressWidth-1:0] r_fifo_addr  [FifoDepth];
  logic [DataWidth-1:0]    r_fifo_wdata [FifoDepth];
  logic [AddressWidth-1:0] r_paddr;
  logic                    r_pwrite;
  logic [DataWidth-1:0]    r_pwdata;
  logic [TW-1:0]           r_tcnt;
  logic                    r_rsp_valid;
  logic [DataWidth-1:0]    r_rsp_rdata;
  logic                    r_rsp_error;
  logic                    r_rsp_timeout;
  logic [DataWidth-1:0]    r_pend_rdata;
  logic                    r_pend_error;
  logic                    r_pend_timeout;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_timeout;
  logic                    w_done;
  logic                    w_slot_free;
  logic [DataWidth-1:0]    w_res_rdata;
  logic                    w_res_error;
  logic                    w_load_rsp;
  logic                    w_load_pend;
  logic                    w_rsp_from_pend;
  logic [1:0]              w_next_state;
  logic [DataWidth-1:0]    w_rsp_rdata_d;
  logic                    w_rsp_error_d;
  logic                    w_rsp_timeout_d;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push  = cmd_valid && !w_full;

  // A timeout fires only when the final allowed ACCESS cycle also lacks pready.
  assign w_timeout   = !pready && (r_tcnt == C_TLAST);
  assign w_done      = pready || w_timeout;
  assign w_slot_free = !r_rsp_valid || rsp_ready;
  assign w_res_rdata = (w_timeout || r_pwrite) ? '0 : prdata;
  assign w_res_error = w_timeout ? 1'b1 : pslverr;

  always_comb begin
    w_next_state    = r_state;
    w_pop           = 1'b0;
    w_load_rsp      = 1'b0;
    w_load_pend     = 1'b0;
    w_rsp_from_pend = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_SETUP;
        end
      end
      S_SETUP: w_next_state = S_ACCESS;
      S_ACCESS: begin
        if (w_done) begin
          if (w_slot_free) begin
            w_load_rsp   = 1'b1;
            w_pop        = !w_empty;
            w_next_state = w_empty ? S_IDLE : S_SETUP;
          end else begin
            w_load_pend  = 1'b1;
            w_next_state = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (w_slot_free) begin
          w_load_rsp      = 1'b1;
          w_rsp_from_pend = 1'b1;
          w_pop           = !w_empty;
          w_next_state    = w_empty ? S_IDLE : S_SETUP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_rsp_rdata_d   = w_rsp_from_pend ? r_pend_rdata   : w_res_rdata;
  assign w_rsp_error_d   = w_rsp_from_pend ? r_pend_error   : w_res_error;
  assign w_rsp_timeout_d = w_rsp_from_pend ? r_pend_timeout : w_timeout;

  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_fifo_write[r_wr_ptr[PW-1:0]] <= cmd_write;
      r_fifo_addr[r_wr_ptr[PW-1:0]]  <= cmd_addr;
      r_fifo_wdata[r_wr_ptr[PW-1:0]] <= cmd_wdata;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_paddr        <= '0;
      r_pwrite       <= 1'b0;
      r_pwdata       <= '0;
      r_tcnt         <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= '0;
      r_rsp_error    <= 1'b0;
      r_rsp_timeout  <= 1'b0;
      r_pend_rdata   <= '0;
      r_pend_error   <= 1'b0;
      r_pend_timeout <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        r_paddr  <= r_fifo_addr[r_rd_ptr[PW-1:0]];
        r_pwrite <= r_fifo_write[r_rd_ptr[PW-1:0]];
        r_pwdata <= r_fifo_write[r_rd_ptr[PW-1:0]] ? r_fifo_wdata[r_rd_ptr[PW-1:0]] : '0;
      end
      if ((r_state == S_ACCESS) && !w_done) begin
        r_tcnt <= r_tcnt + C_TCNT_ONE;
      end else begin
        r_tcnt <= '0;
      end
      if (w_load_pend) begin
        r_pend_rdata   <= w_res_rdata;
        r_pend_error   <= w_res_error;
        r_pend_timeout <= w_timeout;
      end
      if (w_load_rsp) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_rdata   <= w_rsp_rdata_d;
        r_rsp_error   <= w_rsp_error_d;
        r_rsp_timeout <= w_rsp_timeout_d;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign cmd_ready   = !w_full;
  assign psel        = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign penable     = (r_state == S_ACCESS);
  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_error   = r_rsp_error;
  assign rsp_timeout = r_rsp_timeout;
  assign busy        = (r_state != S_IDLE) || !w_empty || r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_apb3_cmd_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb3_cmd_requester
// Description : Scoreboard bench for apb3_cmd_requester with an APB3 memory
//               completer model offering wait states and error injection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb3_cmd_requester;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          rsp_timeout;
  logic          busy;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          psel;
  logic          penable;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  apb3_cmd_requester #(
    .AddressWidth (AW),
    .DataWidth    (DW),
    .FifoDepth    (4),
    .TimeoutCycles(TMO)
  ) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .busy       (busy),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .psel       (psel),
    .penable    (penable),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          error;
    logic          timeout;
  } rsp_t;

  rsp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  logic [DW-1:0] cpl_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_mem [logic [AW-1:0]];
  int            cpl_waits = 0;
  int            cpl_cnt = 0;
  logic          cpl_err = 1'b0;
  int            n_xfers = 0;

  // Completer: decides pready for the upcoming edge; prdata is garbage during waits.
  always @(negedge pclk) begin
    if (presetn && psel && penable) begin
      if (cpl_cnt < cpl_waits) begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'hBAD0_BAD0;
        cpl_cnt++;
      end else begin
        pready  = 1'b1;
        pslverr = cpl_err;
        prdata  = cpl_mem.exists(paddr) ? cpl_mem[paddr] : '0;
        n_xfers++;
        if (pwrite && !cpl_err) cpl_mem[paddr] = pwdata;
      end
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      cpl_cnt = 0;
    end
  end

  always @(negedge pclk) begin
    if (presetn && rsp_valid && rsp_ready) begin
      rsp_t got;
      rsp_t exp;
      got = {rsp_rdata, rsp_error, rsp_timeout};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b to=%b, required no response",
                 rsp_rdata, rsp_error, rsp_timeout);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL rsp_fields: got rdata=%h err=%b to=%b, required rdata=%h err=%b to=%b",
                   got.rdata, got.error, got.timeout, exp.rdata, exp.error, exp.timeout);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output bit saw_full);
    bit   ok;
    rsp_t e;
    saw_full  = 1'b0;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge pclk);
      ok = cmd_ready;
      if (!ok) saw_full = 1'b1;
      @(posedge pclk);
      #1;
    end
    cmd_valid = 1'b0;
    if (ok) begin
      if (cpl_waits >= TMO) begin
        e.rdata = '0; e.error = 1'b1; e.timeout = 1'b1;
      end else begin
        e.rdata   = w ? '0 : (exp_mem.exists(a) ? exp_mem[a] : '0);
        e.error   = cpl_err;
        e.timeout = 1'b0;
        if (w && !cpl_err) exp_mem[a] = d;
      end
      exp_q.push_back(e);
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic test_reset;
    #12;
    n_cmp++;
    if ({psel, penable, pwrite, rsp_valid, rsp_error, rsp_timeout, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got psel/pen/pwr/rv/re/rt/busy=%b, required 0000000",
               {psel, penable, pwrite, rsp_valid, rsp_error, rsp_timeout, busy});
    end
    n_cmp++;
    if ({paddr, pwdata, rsp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h, required all 0",
               paddr, pwdata, rsp_rdata);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
    end
    @(negedge pclk);
    presetn = 1'b1;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_single_write;
    bit sf;
    rsp_ready = 1'b1;
    cpl_waits = 0;
    send_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, sf);
    @(negedge pclk);
    n_cmp++;
    if (psel !== 1'b0) begin
      n_fail++;
      $display("FAIL single_n0_psel: got %b, required 0", psel);
    end
    @(negedge pclk);
    n_cmp++;
    if ({psel, penable, pwrite} !== 3'b101 || paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_setup: got psel/pen/pwr=%b paddr=%h pwdata=%h, required 101 10 deadbeef",
               {psel, penable, pwrite}, paddr, pwdata);
    end
    @(negedge pclk);
    n_cmp++;
    if ({psel, penable} !== 2'b11) begin
      n_fail++;
      $display("FAIL single_access: got psel/pen=%b, required 11", {psel, penable});
    end
    @(negedge pclk);
    n_cmp++;
    if ({rsp_valid, psel} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_rsp: got rsp_valid/psel=%b, required 10", {rsp_valid, psel});
    end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge pclk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_drain: got %0d outstanding, required 0", exp_q.size());
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic test_back_to_back;
    bit saw_full;
    int psel_run;
    saw_full  = 1'b0;
    psel_run  = 0;
    rsp_ready = 1'b1;
    fork
      begin
        bit sf;
        for (int i = 0; i < 4; i++) begin
          send_cmd(1'b1, 32'(i * 4), 32'hA5A5_0000 + 32'(i), sf);
          saw_full |= sf;
        end
        for (int i = 0; i < 4; i++) begin
          send_cmd(1'b0, 32'(i * 4), '0, sf);
          saw_full |= sf;
        end
      end
      begin
        for (int i = 0; i < 100 && !psel; i++) @(negedge pclk);
        while (psel && psel_run < 100) begin
          psel_run++;
          @(negedge pclk);
        end
      end
    join
    n_cmp++;
    if (psel_run != 16) begin
      n_fail++;
      $display("FAIL b2b_psel_run: got %0d continuous psel cycles, required 16", psel_run);
    end
    n_cmp++;
    if (!saw_full) begin
      n_fail++;
      $display("FAIL b2b_cmd_ready: got cmd_ready never low, required low when full");
    end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge pclk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d outstanding, required 0", exp_q.size());
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic test_wait_states;
    bit sf;
    int acc;
    int bad;
    cpl_waits = 3;
    send_cmd(1'b0, 32'h8, '0, sf);
    for (int i = 0; i < 50 && !penable; i++) @(negedge pclk);
    acc = 0;
    bad = 0;
    while (penable && acc < 50) begin
      acc++;
      if (paddr !== 32'h8 || pwrite !== 1'b0) bad++;
      @(negedge pclk);
    end
    n_cmp++;
    if (acc != 4) begin
      n_fail++;
      $display("FAIL wait_access_len: got %0d ACCESS cycles, required 4", acc);
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wait_stable: got %0d unstable cycles, required 0", bad);
    end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge pclk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wait_drain: got %0d outstanding, required 0", exp_q.size());
    end
    cpl_waits = 0;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_timeout;
    bit sf;
    int acc;
    cpl_waits = 1000;
    send_cmd(1'b0, 32'h4, '0, sf);
    for (int i = 0; i < 50 && !penable; i++) @(negedge pclk);
    acc = 0;
    while (penable && acc < 100) begin
      acc++;
      @(negedge pclk);
    end
    n_cmp++;
    if (acc != TMO) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d ACCESS cycles, required %0d", acc, TMO);
    end
    @(posedge pclk);
    #1;
    cpl_waits = 0;
    send_cmd(1'b0, 32'hC, '0, sf);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge pclk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_drain: got %0d outstanding, required 0", exp_q.size());
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic test_slverr;
    bit sf;
    cpl_err = 1'b1;
    send_cmd(1'b1, 32'h20, 32'h1234_5678, sf);
    send_cmd(1'b0, 32'h0, '0, sf);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge pclk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL slverr_drain: got %0d outstanding, required 0", exp_q.size());
    end
    cpl_err = 1'b0;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_stall;
    bit sf;
    int x0;
    rsp_ready = 1'b0;
    x0 = n_xfers;
    send_cmd(1'b0, 32'h0, '0, sf);
    send_cmd(1'b0, 32'h4, '0, sf);
    send_cmd(1'b0, 32'h8, '0, sf);
    repeat (20) @(negedge pclk);
    n_cmp++;
    if (n_xfers - x0 != 2) begin
      n_fail++;
      $display("FAIL stall_xfers: got %0d transfers, required 2", n_xfers - x0);
    end
    n_cmp++;
    if ({psel, penable, rsp_valid, busy} !== 4'b0011) begin
      n_fail++;
      $display("FAIL stall_state: got psel/pen/rv/busy=%b, required 0011",
               {psel, penable, rsp_valid, busy});
    end
    @(posedge pclk);
    #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge pclk);
    n_cmp++;
    if (exp_q.size() != 0 || n_xfers - x0 != 3) begin
      n_fail++;
      $display("FAIL stall_release: got %0d outstanding %0d transfers, required 0 and 3",
               exp_q.size(), n_xfers - x0);
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset_mid;
    bit sf;
    bit saw_psel;
    int x0;
    rsp_ready = 1'b1;
    cpl_waits = 1000;
    send_cmd(1'b0, 32'h0, '0, sf);
    send_cmd(1'b0, 32'h4, '0, sf);
    send_cmd(1'b0, 32'h8, '0, sf);
    for (int i = 0; i < 50 && !penable; i++) @(negedge pclk);
    #2;
    presetn = 1'b0;
    #1;
    exp_q.delete();
    x0 = n_xfers;
    n_cmp++;
    if ({psel, penable, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL rstmid_async: got psel/pen/rv/busy/cmd_ready=%b, required 00001",
               {psel, penable, rsp_valid, busy, cmd_ready});
    end
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    presetn   = 1'b1;
    cpl_waits = 0;
    saw_psel  = 1'b0;
    repeat (20) begin
      @(negedge pclk);
      if (psel || penable) saw_psel = 1'b1;
    end
    n_cmp++;
    if (saw_psel || n_xfers != x0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: got bus_activity=%b xfers=%0d busy=%b, required 0 0 0",
               saw_psel, n_xfers - x0, busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_slverr();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
